uart_byte_rx: RTL and testbench

- Serial-to-byte UART receiver, 8N1, LSB first, 16x oversampling.
- Sits directly upstream of the image RAM writer.
- Its rx_data/rx_done outputs drive that stage's byte inputs one-to-one.
- Samples each bit near mid-bit with a 3-sample majority vote, rejects start-bit glitches and flags framing errors.

---
 rtl/uart_byte_rx.sv | 184 ++++++++++++++++++
 tb/tb_uart_byte_rx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 serial-to-byte receiver, LSB first, 16x oversampling.
// Each bit is the majority of three samples taken around mid-bit (sample
// ticks 7, 8, 9). A start bit that does not vote low is dropped as a glitch.
// A stop bit that votes low raises frame_err, and the receiver then waits
// for the line to return high before it looks for a new start edge.
//
// Ports:
//   Clk       - system clock
//   Reset_n   - asynchronous active-low reset
//   uart_rx   - asynchronous serial line, idles high
//   rx_data   - last correctly received byte, held between pulses
//   rx_done   - one-cycle pulse, rx_data is new
//   frame_err - one-cycle pulse, stop bit sampled low
//   rx_busy   - high while a frame is in progress
module uart_byte_rx #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  // Rounded clocks per oversample tick; must be at least 2.
  localparam int unsigned BAUD_DIV = (CLK_FREQ + BAUD * 8) / (BAUD * 16);
  localparam int unsigned DivW     = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e state_q, state_d;

  // Two synchronizer stages plus one stage for falling-edge detection.
  logic sync1_q, sync2_q, sync3_q;
  logic rx_s;
  logic start_edge;

  logic [DivW-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]      samp_cnt_q, samp_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            s7_q, s7_d;
  logic            s8_q, s8_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_done_q, rx_done_d;
  logic            frame_err_q, frame_err_d;

  logic tick;
  logic mid_tick;
  logic end_tick;
  logic vote;

  assign rx_s       = sync2_q;
  assign start_edge = sync3_q & ~sync2_q;
  assign tick       = (div_cnt_q == DivMax);
  assign mid_tick   = tick && (samp_cnt_q == 4'd9);
  assign end_tick   = tick && (samp_cnt_q == 4'd15);
  // Third sample is the live line at the samp_cnt==9 tick.
  assign vote       = (s7_q & s8_q) | (s7_q & rx_s) | (s8_q & rx_s);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  // State register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start_edge) state_d = StStart;
      end
      StStart: begin
        if (mid_tick && vote) begin
          state_d = StIdle;
        end else if (end_tick) begin
          state_d = StData;
        end
      end
      StData: begin
        if (end_tick && (bit_idx_q == 3'd7)) state_d = StStop;
      end
      StStop: begin
        // Decide at mid stop bit so a back-to-back start edge is not missed.
        if (mid_tick) state_d = vote ? StIdle : StWaitHigh;
      end
      StWaitHigh: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    rx_busy     = (state_q != StIdle);
    rx_done_d   = (state_q == StStop) && mid_tick && vote;
    frame_err_d = (state_q == StStop) && mid_tick && !vote;
    rx_data_d   = rx_done_d ? shift_q : rx_data_q;
  end

  // Oversampling counters, sample capture and the holding shift register.
  always_comb begin
    div_cnt_d  = div_cnt_q;
    samp_cnt_d = samp_cnt_q;
    bit_idx_d  = bit_idx_q;
    s7_d       = s7_q;
    s8_d       = s8_q;
    shift_d    = shift_q;

    if (state_q == StIdle) begin
      // Held at zero so the start edge begins a bit period cleanly.
      div_cnt_d  = '0;
      samp_cnt_d = '0;
      bit_idx_d  = '0;
    end else if (tick) begin
      div_cnt_d  = '0;
      samp_cnt_d = samp_cnt_q + 4'd1;
    end else begin
      div_cnt_d = div_cnt_q + DivW'(1);
    end

    if (tick && (samp_cnt_q == 4'd7)) s7_d = rx_s;
    if (tick && (samp_cnt_q == 4'd8)) s8_d = rx_s;

    if ((state_q == StData) && mid_tick) shift_d = {vote, shift_q[7:1]};
    if ((state_q == StData) && end_tick) bit_idx_d = bit_idx_q + 3'd1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt_q   <= '0;
      samp_cnt_q  <= '0;
      bit_idx_q   <= '0;
      s7_q        <= 1'b1;
      s8_q        <= 1'b1;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      div_cnt_q   <= div_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      bit_idx_q   <= bit_idx_d;
      s7_q        <= s7_d;
      s8_q        <= s8_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// Randomised and directed bench for uart_byte_rx. Frames are driven at the
// pin level; each frame pushes its expected outcome (byte or framing error)
// into a queue, and an independent monitor pops and compares on every pulse.
module tb_uart_byte_rx;

  localparam int unsigned ClkFreq = 1_600_000;
  localparam int unsigned Baud    = 10_000;
  localparam int          Bit     = 160;  // clocks per bit at these rates

  typedef struct packed {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  int   n_tests;
  int   n_fails;
  exp_t exp_q[$];
  logic [7:0] last_good;  // model of the byte rx_data should hold
  logic       done_prev;
  logic       ferr_prev;

  uart_byte_rx #(
    .CLK_FREQ(ClkFreq),
    .BAUD    (Baud)
  ) dut (
    .Clk      (clk),
    .Reset_n  (rst_n),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one 8N1 frame; spike_at >= 0 inverts the pin for 2 clocks there.
  task automatic send_frame(input logic [7:0] d, input bit stop_hi, input int spike_at);
    logic [9:0] f;
    exp_t       e;
    f        = {stop_hi, d, 1'b0};
    e.is_err = ~stop_hi;
    e.data   = stop_hi ? d : 8'h00;
    exp_q.push_back(e);
    for (int i = 0; i < 10 * Bit; i++) begin
      uart_rx = f[i / Bit] ^ ((spike_at >= 0 && i >= spike_at && i < spike_at + 2) ? 1'b1 : 1'b0);
      @(negedge clk);
    end
    uart_rx = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    uart_rx = 1'b1;
    repeat (n * Bit) @(negedge clk);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst_n && (rx_done || frame_err)) begin
      check("pulse_exclusive", {31'd0, rx_done & frame_err}, 32'd0);
      check("event_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        if (rx_done) begin
          check("done_not_err", {31'd0, e.is_err}, 32'd0);
          check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
          if (!e.is_err) last_good = e.data;
        end else begin
          check("ferr_expected", {31'd0, e.is_err}, 32'd1);
          check("rx_data_held_on_ferr", {24'd0, rx_data}, {24'd0, last_good});
        end
      end
    end
    if (done_prev && rx_done) check("rx_done_width", 32'd2, 32'd1);
    if (ferr_prev && frame_err) check("frame_err_width", 32'd2, 32'd1);
    done_prev <= rx_done;
    ferr_prev <= frame_err;
  end

  initial begin
    n_tests   = 0;
    n_fails   = 0;
    last_good = 8'h00;
    uart_rx   = 1'b1;
    rst_n     = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_rx_done", {31'd0, rx_done}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    rst_n = 1'b1;
    idle_bits(2);

    // Single byte.
    send_frame(8'h55, 1'b1, -1);
    idle_bits(1);
    check("single_0x55", {24'd0, rx_data}, 32'h55);

    // Back-to-back frames, last value held.
    send_frame(8'hA3, 1'b1, -1);
    send_frame(8'h00, 1'b1, -1);
    send_frame(8'hFF, 1'b1, -1);
    idle_bits(3);
    check("held_0xff", {24'd0, rx_data}, 32'hFF);
    check("idle_not_busy", {31'd0, rx_busy}, 32'd0);

    // Start-bit glitch.
    uart_rx = 1'b0;
    repeat (40) @(negedge clk);
    check("glitch_busy", {31'd0, rx_busy}, 32'd1);
    uart_rx = 1'b1;
    repeat (Bit - 40) @(negedge clk);
    check("glitch_recovered", {31'd0, rx_busy}, 32'd0);
    idle_bits(1);
    send_frame(8'h3C, 1'b1, -1);
    idle_bits(1);

    // Framing error followed by a held break.
    send_frame(8'h81, 1'b0, -1);
    uart_rx = 1'b0;
    repeat (5 * Bit) @(negedge clk);
    check("break_busy", {31'd0, rx_busy}, 32'd1);
    check("break_data_held", {24'd0, rx_data}, {24'd0, last_good});
    uart_rx = 1'b1;
    repeat (10) @(negedge clk);
    check("break_released", {31'd0, rx_busy}, 32'd0);
    idle_bits(1);
    send_frame(8'h42, 1'b1, -1);
    idle_bits(1);

    // Spike near mid data bit 3 (frame bit 4).
    send_frame(8'hF0, 1'b1, 4 * Bit + 90);
    idle_bits(1);
    check("spike_rejected", {24'd0, rx_data}, 32'hF0);

    // Reset during data bit 4 (frame bit 5) of an aborted frame.
    for (int i = 0; i < 5 * Bit + 80; i++) begin
      logic [9:0] f;
      f       = {1'b1, 8'h77, 1'b0};
      uart_rx = f[i / Bit];
      @(negedge clk);
    end
    rst_n     = 1'b0;
    uart_rx   = 1'b1;
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    check("midreset_rx_data", {24'd0, rx_data}, 32'd0);
    check("midreset_rx_done", {31'd0, rx_done}, 32'd0);
    check("midreset_frame_err", {31'd0, frame_err}, 32'd0);
    check("midreset_rx_busy", {31'd0, rx_busy}, 32'd0);
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(2);
    send_frame(8'h9E, 1'b1, -1);
    idle_bits(1);
    check("after_reset_0x9e", {24'd0, rx_data}, 32'h9E);

    // Random frames: random data, gaps, single spikes, occasional bad stop.
    for (int n = 0; n < 12; n++) begin
      logic [7:0] d;
      bit         stop_hi;
      int         spike;
      d       = 8'($urandom);
      stop_hi = ($urandom_range(7) != 0);
      spike   = ($urandom_range(1) != 0)
                ? (Bit * (1 + $urandom_range(7)) + $urandom_range(Bit - 3)) : -1;
      send_frame(d, stop_hi, spike);
      idle_bits(stop_hi ? $urandom_range(2) : 1 + $urandom_range(1));
    end

    for (int k = 0; k < 4 * Bit && exp_q.size() != 0; k++) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    check("final_rx_data", {24'd0, rx_data}, {24'd0, last_good});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
